axi_wr_arb: RTL
===============

AXI_WR_ARB -- requirements
Module: axi_wr_arb

Interface
REQ-001 The block SHALL have no parameters: two requesters, 32-bit address and data, 4-bit byte strobe, 4-bit ID, all fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 areset  input  1  asynchronous, active-high reset.
REQ-004 req_valid_i  input  2  bit i: requester i has a write pending.
REQ-005 req_addr_i  input  64  requester i address at [32i+31:32i].
REQ-006 req_data_i  input  64  requester i data at [32i+31:32i].
REQ-007 req_strb_i  input  8  requester i byte strobes at [4i+3:4i].
REQ-008 req_ready_o  output  2  bit i: request i accepted this cycle (valid&ready handshake).
REQ-009 done_valid_o  output  2  bit i: one-cycle pulse, write i completed.
REQ-010 done_resp_o  output  2  response code for the pulsing done bit.
REQ-011 awid_o / awaddr_o / awvalid_o  output  4 / 32 / 1  AXI write-address channel.
REQ-012 awready_i  input  1  AXI write-address ready.
REQ-013 wid_o / wdata_o / wstrb_o / wlast_o / wvalid_o  output  4 / 32 / 4 / 1 / 1  AXI write-data channel.
REQ-014 wready_i  input  1  AXI write-data ready.
REQ-015 bid_i / bresp_i / bvalid_i  input  4 / 2 / 1  AXI write-response channel.
REQ-016 bready_o  output  1  AXI write-response ready.

Function
REQ-017 FSM states SHALL be IDLE, SEND, RESP; exactly one write SHALL be outstanding at any time.
REQ-018 Grant: IDLE only; round-robin, priority to the requester not granted last; a single valid requester SHALL win immediately.
REQ-019 req_ready_o SHALL be combinational: bit i high iff state==IDLE and requester i wins; all other times 2'b00.
REQ-020 Accept (valid&ready in IDLE): addr/data/strb of the winner SHALL be captured, grant index held, state -> SEND next cycle.
REQ-021 awid_o and wid_o SHALL equal the zero-extended grant index (0 or 1); wlast_o SHALL be constant 1 (single beat).
REQ-022 SEND: awvalid_o and wvalid_o SHALL both assert on the first SEND cycle; each SHALL drop after its own handshake, independently, in any order or together.
REQ-023 Channel outputs SHALL stay stable while the matching valid is high and not accepted.
REQ-024 After both AW and W handshakes: state -> RESP; bready_o SHALL be 1 only in RESP.
REQ-025 RESP on bvalid_i: done_valid_o[grant] SHALL pulse for that cycle; done_resp_o = bresp_i, except 2'b10 (SLVERR) if bid_i != awid_o; state -> IDLE, last-grant pointer updated.
REQ-026 Minimum latency with always-ready slave: accept cycle 0, AW/W cycle 1, B cycle 2 earliest, next accept cycle 3.
REQ-027 Both requesters valid continuously SHALL alternate 0,1,0,1...; a requester dropping valid before acceptance SHALL NOT be granted.
REQ-028 bvalid_i outside RESP SHALL be ignored (no done pulse, no state change).
REQ-029 done_resp_o SHALL be 2'b00 when no done bit is set.

Reset
REQ-030 While areset is high, state SHALL be IDLE, all outputs 0 except wlast_o=1, and the last-grant pointer SHALL be 1 so requester 0 wins first.
REQ-031 Reset asserted mid-transaction SHALL drop the pending write immediately: no done pulse; awvalid_o/wvalid_o/bready_o go low asynchronously.

Verification
REQ-032 Req0 alone, addr 0x4, data 0xDEADBEEF, strb 0xF, slave always ready -> req_ready_o=01 cycle 0, AW/W with awid 0 cycle 1, done_valid_o=01, resp 00.
REQ-033 Both valid continuously, 4 writes -> grants 0,1,0,1; each done pulse on the matching bit.
REQ-034 awready_i held low 3 cycles, wready_i immediate -> wvalid_o drops after 1 cycle, awvalid_o held with awaddr stable 4 cycles, then RESP.
REQ-035 Req1 write, bid_i=0 returned with bresp 00 -> done_valid_o=10, done_resp_o=10.
REQ-036 areset pulsed in RESP -> no done pulse; after release req0 and req1 both valid -> req0 granted first.

Source files
------------

// File: rtl/axi_wr_arb_if.sv
// axi_wr_arb_if: request, completion and AXI write-channel signals of the two-requester write arbiter
interface axi_wr_arb_if;
  logic [1:0]  req_valid_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_data_i;
  logic [7:0]  req_strb_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  done_valid_o;
  logic [1:0]  done_resp_o;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [3:0]  wid_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;
  modport master (
    input  req_valid_i, req_addr_i, req_data_i, req_strb_i, awready_i, wready_i, bid_i, bresp_i, bvalid_i,
    output req_ready_o, done_valid_o, done_resp_o, awid_o, awaddr_o, awvalid_o,
           wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
  );
  modport slave (
    output req_valid_i, req_addr_i, req_data_i, req_strb_i, awready_i, wready_i, bid_i, bresp_i, bvalid_i,
    input  req_ready_o, done_valid_o, done_resp_o, awid_o, awaddr_o, awvalid_o,
           wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o
  );
endinterface

// File: rtl/axi_wr_arb.sv
// axi_wr_arb: round-robin arbiter issuing single-beat AXI writes for two requesters, one outstanding at a time
module axi_wr_arb (
  input logic clk,
  input logic areset,
  axi_wr_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;
  state_t      r_state;
  logic        r_last, r_gnt, r_awvalid, r_wvalid;
  logic [31:0] r_addr, r_data;
  logic [3:0]  r_strb;
  logic        w_sel, w_acc, w_aw_hs, w_w_hs, w_b_hs;
  logic [3:0]  w_id;
  // requester 1 wins when it is alone or when requester 0 was granted last
  assign w_sel   = bus.req_valid_i[1] & (~bus.req_valid_i[0] | ~r_last);
  assign w_acc   = ~areset & (r_state == IDLE) & (|bus.req_valid_i);
  assign w_aw_hs = r_awvalid & bus.awready_i;
  assign w_w_hs  = r_wvalid & bus.wready_i;
  assign w_b_hs  = (r_state == RESP) & bus.bvalid_i;
  assign w_id    = {3'b000, r_gnt};
  assign bus.req_ready_o  = w_acc ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.awid_o       = w_id;
  assign bus.wid_o        = w_id;
  assign bus.awaddr_o     = r_addr;
  assign bus.awvalid_o    = r_awvalid;
  assign bus.wdata_o      = r_data;
  assign bus.wstrb_o      = r_strb;
  assign bus.wlast_o      = 1'b1;
  assign bus.wvalid_o     = r_wvalid;
  assign bus.bready_o     = (r_state == RESP);
  assign bus.done_valid_o = w_b_hs ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign bus.done_resp_o  = !w_b_hs ? 2'b00 : (bus.bid_i != w_id) ? 2'b10 : bus.bresp_i;
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else if (w_acc) begin
      r_state   <= SEND;
      r_gnt     <= w_sel;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_addr    <= w_sel ? bus.req_addr_i[63:32] : bus.req_addr_i[31:0];
      r_data    <= w_sel ? bus.req_data_i[63:32] : bus.req_data_i[31:0];
      r_strb    <= w_sel ? bus.req_strb_i[7:4] : bus.req_strb_i[3:0];
    end else if (r_state == SEND) begin
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs) r_wvalid <= 1'b0;
      if ((~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs)) r_state <= RESP;
    end else if (w_b_hs) begin
      r_state <= IDLE;
      r_last  <= r_gnt;
    end
  end
endmodule
